axi_cmd_master: RTL and testbench
=================================

// Module: axi_cmd_master
// PURPOSE
// - Single-outstanding AXI4-Lite-style initiator (32b addr, 64b data) that drives the accelerator's S_AXI slave port.
// - Used in bring-up/standalone systems and as the bench host model.
// - Executes queued commands (write / read / poll), e.g. seed load, distance-table load, ordering load, run start,
//   wait-for-not-running, ordering/distance readback.
// - Returns one response per command.
// PARAMETERS
// - CMD_DEPTH      4    command FIFO entries, power of 2, >=2
// - POLL_INTERVAL  16   idle cycles between poll reads, >=1
// - POLL_MAX       1024 poll reads before timeout, >=1
// PORTS
// - M_AXI_ACLK     in   1   single clock
// - M_AXI_ARESETN  in   1   reset, asynchronous assert, active-low
// - cmd_valid      in   1   command offer
// - cmd_ready      out  1   command accepted when valid&ready
// - cmd_op         in   2   axi_cmd_op_t: 0 WRITE, 1 READ, 2 POLL, 3 reserved
// - cmd_addr       in   32  byte address
// - cmd_wdata      in   64  WRITE data / POLL bit mask
// - cmd_wstrb      in   8   WRITE byte strobes
// - rsp_valid      out  1   response offer
// - rsp_ready      in   1   response consumed when valid&ready
// - rsp_op         out  2   echo of cmd_op
// - rsp_data       out  64  RDATA (READ/POLL), 0 for WRITE
// - rsp_resp       out  2   BRESP/RRESP, 2'b10 on timeout or illegal op
// - busy           out  1   FSM not IDLE or FIFO not empty
// - err_cnt        out  8   saturating count of non-OKAY responses
// - M_AXI_AW*/W*/B*/AR*/R*  AXI master channels mirroring the slave: AWADDR/ARADDR 32, WDATA/RDATA 64, WSTRB 8, BRESP/RRESP 2
// BEHAVIOUR
// - Reset values: all *VALID=0, BREADY=RREADY=0, rsp_valid=0, busy=0, err_cnt=0, cmd_ready=0 while reset is asserted.
//   After reset, cmd_ready=1. FIFO contents are discarded.
// - cmd_ready = !fifo_full. A push while full is refused even if a pop occurs in the same cycle.
// - FSM states: IDLE, WR (AW+W), WR_B, RD_A, RD_R, POLL_WAIT, RSP.
// - IDLE: pops when FIFO not empty; the cmd is registered.
//   - WRITE -> WR; READ/POLL -> RD_A; reserved op -> RSP with resp 2'b10 and no bus traffic.
//   - Idle latency: cmd handshake at edge N, FIFO pop at edge N+1, AWVALID/WVALID or ARVALID high after edge N+2.
// - WR: AWVALID and WVALID are raised together and each drops independently on its own handshake (either order or
//   same cycle). Go to WR_B once both are done.
// - WR_B: BREADY=1. On BVALID, capture BRESP -> RSP with rsp_data=0.
// - RD_A: ARVALID until ARREADY -> RD_R. RD_R: RREADY=1; on RVALID capture RDATA/RRESP.
//   - READ -> RSP.
//   - POLL -> see CONFIGURATION.
// - AXI rules: addr/data/strb stable while VALID is high. VALID never drops before its handshake. Never more than
//   one transaction outstanding.
// - RSP: rsp_valid=1 until rsp_ready, then IDLE. Backpressure stalls the next command; the FIFO keeps accepting
//   until full.
// - err_cnt: +1 for each RSP entry with rsp_resp!=2'b00, saturating at 8'hFF.
// - Asynchronous reset mid-transaction: all VALIDs drop at once and the transaction is abandoned. No response is
//   generated.
// CONFIGURATION
// - AXI_MASTER_POLL_EN defined:
//   - POLL: read cmd_addr; if (RDATA & mask)==0, go to RSP with that RDATA and RRESP.
//   - Else wait POLL_INTERVAL cycles in POLL_WAIT, then RD_A again.
//   - A non-OKAY RRESP ends the poll immediately.
//   - After POLL_MAX reads without success: RSP with last RDATA and resp 2'b10.
// - AXI_MASTER_POLL_EN undefined: POLL is treated as a reserved op (RSP, resp 2'b10, no bus traffic, err_cnt+1).
//   POLL_WAIT and its counters are not built.
// STRUCTURE
// - replica_pkg adds: axi_cmd_op_t enum (WRITE/READ/POLL/RSVD); axi_cmd_t struct {op, addr, wdata, wstrb};
//   axi_rsp_t struct {op, data, resp}; AXI_RESP_OKAY, AXI_RESP_SLVERR localparams.
// - Sub-module axi_cmd_fifo: synchronous FIFO of axi_cmd_t, CMD_DEPTH entries, full/empty flags, async active-low
//   reset.
// - FSM, poll counters and response register live in axi_cmd_master.
// TESTING
// - Reset, then WRITE addr 0x0000_0010 data 0x1234 strb 0xFF:
//   AW/W valid 2 cycles after cmd; rsp resp=0, data=0; err_cnt=0.
// - Slave delays AWREADY 3 cycles and WREADY 0 cycles:
//   WVALID drops after 1 cycle, AWVALID after 4; exactly one B accepted; one rsp.
// - Push 5 cmds with CMD_DEPTH=4 while rsp_ready=0:
//   cmd_ready=0 on the 5th. After rsp_ready=1, 5 rsps arrive in order and no command is lost.
// - READ with slave RRESP=2'b10, RDATA=0xDEAD:
//   rsp data=0xDEAD, resp=2'b10; err_cnt=1. 256 such reads -> err_cnt=0xFF.
// - POLL mask 0x1 with POLL_EN, slave returns 1,1,0:
//   3 ARs spaced POLL_INTERVAL apart; rsp data=0, resp=0. Slave always 1, POLL_MAX=4 -> 4 ARs, resp=2'b10.
//   Without the macro: no AR, resp=2'b10.
// - ARESETN low while ARVALID is high: ARVALID=0 immediately; busy=0, rsp_valid=0. Next cmd runs normally.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types for the accelerator host-side command master: command/response
// records, op codes, AXI response codes and the master FSM state encoding.
package replica_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_POLL  = 2'd2,
      OP_RSVD  = 2'd3
   } axi_cmd_op_t;

   typedef struct packed {
      axi_cmd_op_t op;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } axi_cmd_t;

   typedef struct packed {
      axi_cmd_op_t op;
      logic [63:0] data;
      logic [1:0]  resp;
   } axi_rsp_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_B,
      ST_RD_A,
      ST_RD_R,
      ST_POLL_WAIT,
      ST_RSP
   } axi_mst_state_t;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Command FIFO for axi_cmd_master. Pointers carry one wrap bit so full/empty
// need no separate counter; a push while full is refused even if a pop happens.
module axi_cmd_fifo
   import replica_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_sys,
   input  logic     rst_b,
   input  logic     push,
   input  axi_cmd_t push_data,
   input  logic     pop,
   output axi_cmd_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   axi_cmd_t    mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // storage needs no reset: stale entries are unreachable once pointers clear
   always_ff @(posedge clk_sys) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4-Lite-style initiator executing queued write/read/poll
// commands. Optional macro AXI_MASTER_POLL_EN builds the polling engine.
//
// state        | meaning
// IDLE         | pop next command, then dispatch it one cycle later
// WR           | AWVALID/WVALID up, each dropped on its own handshake
// WR_B         | BREADY up, waiting for write response
// RD_A         | ARVALID up, waiting for ARREADY
// RD_R         | RREADY up, waiting for read data
// POLL_WAIT    | idle gap between poll reads (poll build only)
// RSP          | rsp_valid up until consumed
module axi_cmd_master
   import replica_pkg::*;
#(
   parameter int CMD_DEPTH     = 4,
   parameter int POLL_INTERVAL = 16,
   parameter int POLL_MAX      = 1024
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESETN,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  axi_cmd_op_t cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [63:0] cmd_wdata,
   input  logic [7:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output axi_cmd_op_t rsp_op,
   output logic [63:0] rsp_data,
   output logic [1:0]  rsp_resp,
   output logic        busy,
   output logic [7:0]  err_cnt,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   output logic [63:0] M_AXI_WDATA,
   output logic [7:0]  M_AXI_WSTRB,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   input  logic [1:0]  M_AXI_BRESP,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   output logic [31:0] M_AXI_ARADDR,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY,
   input  logic [63:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP
);

   axi_mst_state_t state_q, state_d;
   axi_cmd_t       cmd_q, cmd_d, fifo_rd;
   logic           cmd_vld_q, cmd_vld_d;
   logic           aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [63:0]    rsp_data_q, rsp_data_d;
   logic [1:0]     rsp_resp_q, rsp_resp_d;
   logic [7:0]     err_cnt_q, err_cnt_d;
   logic           init_q;
   logic           fifo_full, fifo_empty, fifo_pop;

`ifdef AXI_MASTER_POLL_EN
   localparam int PMW = $clog2(POLL_MAX + 1);
   localparam int PIW = $clog2(POLL_INTERVAL + 1);
   logic [PMW-1:0] poll_left_q, poll_left_d;
   logic [PIW-1:0] wait_q, wait_d;
`endif

   axi_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .clk_sys   (M_AXI_ACLK),
      .rst_b     (M_AXI_ARESETN),
      .push      (cmd_valid && cmd_ready),
      .push_data ('{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      cmd_vld_d  = cmd_vld_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      rsp_data_d = rsp_data_q;
      rsp_resp_d = rsp_resp_q;
      err_cnt_d  = err_cnt_q;
      fifo_pop   = 1'b0;
`ifdef AXI_MASTER_POLL_EN
      poll_left_d = poll_left_q;
      wait_d      = wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_vld_q) begin
               cmd_vld_d = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               case (cmd_q.op)
                  OP_WRITE: state_d = ST_WR;
                  OP_READ:  state_d = ST_RD_A;
`ifdef AXI_MASTER_POLL_EN
                  OP_POLL: begin
                     state_d     = ST_RD_A;
                     poll_left_d = PMW'(POLL_MAX);
                  end
`endif
                  default: begin
                     rsp_data_d = '0;
                     rsp_resp_d = AXI_RESP_SLVERR;
                     state_d    = ST_RSP;
                  end
               endcase
            end else if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               cmd_d     = fifo_rd;
               cmd_vld_d = 1'b1;
            end
         end
         ST_WR: begin
            aw_done_d = aw_done_q | M_AXI_AWREADY;
            w_done_d  = w_done_q | M_AXI_WREADY;
            if (aw_done_d && w_done_d) state_d = ST_WR_B;
         end
         ST_WR_B: begin
            if (M_AXI_BVALID) begin
               rsp_data_d = '0;
               rsp_resp_d = M_AXI_BRESP;
               state_d    = ST_RSP;
            end
         end
         ST_RD_A: begin
            if (M_AXI_ARREADY) state_d = ST_RD_R;
         end
         ST_RD_R: begin
            if (M_AXI_RVALID) begin
               rsp_data_d = M_AXI_RDATA;
               rsp_resp_d = M_AXI_RRESP;
               state_d    = ST_RSP;
`ifdef AXI_MASTER_POLL_EN
               // an error response or a cleared masked field ends the poll
               if (cmd_q.op == OP_POLL && M_AXI_RRESP == AXI_RESP_OKAY &&
                   (M_AXI_RDATA & cmd_q.wdata) != '0) begin
                  if (poll_left_q == PMW'(1)) begin
                     rsp_resp_d = AXI_RESP_SLVERR;
                  end else begin
                     poll_left_d = poll_left_q - PMW'(1);
                     wait_d      = PIW'(POLL_INTERVAL);
                     state_d     = ST_POLL_WAIT;
                  end
               end
`endif
            end
         end
`ifdef AXI_MASTER_POLL_EN
         ST_POLL_WAIT: begin
            if (wait_q == PIW'(1)) state_d = ST_RD_A;
            else                   wait_d  = wait_q - PIW'(1);
         end
`endif
         ST_RSP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_RSP && state_q != ST_RSP &&
          rsp_resp_d != AXI_RESP_OKAY && err_cnt_q != 8'hFF)
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         cmd_vld_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_resp_q <= AXI_RESP_OKAY;
         err_cnt_q  <= '0;
         init_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cmd_vld_q  <= cmd_vld_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         rsp_data_q <= rsp_data_d;
         rsp_resp_q <= rsp_resp_d;
         err_cnt_q  <= err_cnt_d;
         init_q     <= 1'b1;
      end
   end

`ifdef AXI_MASTER_POLL_EN
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         poll_left_q <= '0;
         wait_q      <= '0;
      end else begin
         poll_left_q <= poll_left_d;
         wait_q      <= wait_d;
      end
   end
`endif

   // init_q keeps cmd_ready low through reset and the first clock after it
   assign cmd_ready     = init_q && !fifo_full;
   assign busy          = (state_q != ST_IDLE) || cmd_vld_q || !fifo_empty;
   assign rsp_valid     = (state_q == ST_RSP);
   assign rsp_op        = cmd_q.op;
   assign rsp_data      = rsp_data_q;
   assign rsp_resp      = rsp_resp_q;
   assign err_cnt       = err_cnt_q;

   assign M_AXI_AWVALID = (state_q == ST_WR) && !aw_done_q;
   assign M_AXI_WVALID  = (state_q == ST_WR) && !w_done_q;
   assign M_AXI_AWADDR  = cmd_q.addr;
   assign M_AXI_WDATA   = cmd_q.wdata;
   assign M_AXI_WSTRB   = cmd_q.wstrb;
   assign M_AXI_BREADY  = (state_q == ST_WR_B);
   assign M_AXI_ARVALID = (state_q == ST_RD_A);
   assign M_AXI_ARADDR  = cmd_q.addr;
   assign M_AXI_RREADY  = (state_q == ST_RD_R);

endmodule

// File: tb/tb_axi_cmd_master.sv
// Scoreboard bench for axi_cmd_master: directed commands against a simple
// reactive AXI slave; responses are checked by an independent monitor.
module tb_axi_cmd_master;
   import replica_pkg::*;

   localparam int CMD_DEPTH     = 4;
   localparam int POLL_INTERVAL = 4;
   localparam int POLL_MAX      = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready;
   axi_cmd_op_t cmd_op;
   logic [31:0] cmd_addr;
   logic [63:0] cmd_wdata;
   logic [7:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   axi_cmd_op_t rsp_op;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic        busy;
   logic [7:0]  err_cnt;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axi_cmd_master #(.CMD_DEPTH(CMD_DEPTH), .POLL_INTERVAL(POLL_INTERVAL), .POLL_MAX(POLL_MAX)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .busy(busy), .err_cnt(err_cnt),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
   );

   int checks = 0;
   int failures = 0;
   int n_rsp = 0;
   axi_rsp_t exp_q[$];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   function automatic axi_rsp_t mk(axi_cmd_op_t op, logic [63:0] d, logic [1:0] r);
      axi_rsp_t x;
      x.op = op; x.data = d; x.resp = r;
      return x;
   endfunction

   // response monitor: handshake happens at the posedge after this sample point
   initial begin
      axi_rsp_t e;
      forever begin
         @(negedge clk); #1;
         if (rst_n && rsp_valid && rsp_ready) begin
            chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_op",   64'(rsp_op),   64'(e.op));
               chk("rsp_data", rsp_data,      e.data);
               chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
               n_rsp++;
            end
         end
      end
   end

   // reactive slave: every decision is made on the negedge and takes effect at the next posedge
   int aw_delay = 0, w_delay = 0, ar_delay = 0;
   int aw_cnt, w_cnt, ar_cnt, aw_hi, w_hi, last_aw_hi, last_w_hi;
   int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, cyc = 0;
   bit aw_got, w_got, ar_got, b_pend, r_pend;
   logic [31:0] last_awaddr, last_araddr;
   logic [63:0] last_wdata;
   logic [7:0]  last_wstrb;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [63:0] rdata_dflt = '0;
   logic [63:0] rdata_fifo[$];
   int          ar_cyc[$];

   initial begin
      {awready, wready, bvalid, arready, rvalid} = '0;
      bresp = '0; rresp = '0; rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            {awready, wready, bvalid, arready, rvalid} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_hi = 0; w_hi = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
         end else begin
            if (b_pend) begin bvalid = 1'b0; b_hs_n++; end
            if (r_pend) rvalid = 1'b0;
            if (aw_got && w_got && !bvalid) begin
               bvalid = 1'b1; bresp = bresp_cfg; aw_got = 0; w_got = 0;
            end
            if (ar_got && !rvalid) begin
               rvalid = 1'b1; rresp = rresp_cfg;
               rdata = (rdata_fifo.size() != 0) ? rdata_fifo.pop_front() : rdata_dflt;
               ar_got = 0;
            end
            awready = 1'b0;
            if (awvalid) begin
               aw_hi++;
               if (aw_cnt >= aw_delay) begin
                  awready = 1'b1; aw_hs_n++; last_aw_hi = aw_hi; aw_hi = 0; aw_cnt = 0;
                  last_awaddr = awaddr; aw_got = 1;
               end else aw_cnt++;
            end
            wready = 1'b0;
            if (wvalid) begin
               w_hi++;
               if (w_cnt >= w_delay) begin
                  wready = 1'b1; w_hs_n++; last_w_hi = w_hi; w_hi = 0; w_cnt = 0;
                  last_wdata = wdata; last_wstrb = wstrb; w_got = 1;
               end else w_cnt++;
            end
            arready = 1'b0;
            if (arvalid) begin
               if (ar_cnt >= ar_delay) begin
                  arready = 1'b1; ar_hs_n++; ar_cyc.push_back(cyc); ar_cnt = 0;
                  last_araddr = araddr; ar_got = 1;
               end else ar_cnt++;
            end
            b_pend = bvalid && bready;
            r_pend = rvalid && rready;
         end
      end
   end

   // called on a negedge; returns on the negedge after the accepting posedge
   task automatic send(input axi_cmd_op_t op, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input axi_rsp_t e);
      int t = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      chk("send_ready", 64'(cmd_ready), 64'd1);
      if (cmd_ready) exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 800) begin @(negedge clk); t++; end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, c0, r0;
      cmd_valid = 1'b0; cmd_op = OP_WRITE; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_err_cnt",   64'(err_cnt),   64'd0);
      chk("rst_valids",    64'({awvalid, wvalid, arvalid}), 64'd0);
      chk("rst_readies",   64'({bready, rready}), 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // basic write with idle latency: AW/W appear after the second edge past the handshake
      send(OP_WRITE, 32'h10, 64'h1234, 8'hFF, mk(OP_WRITE, 64'h0, AXI_RESP_OKAY));
      chk("lat_edge_n",  64'(awvalid), 64'd0);
      @(negedge clk);
      chk("lat_edge_n1", 64'(awvalid), 64'd0);
      @(negedge clk);
      chk("lat_edge_n2", 64'({awvalid, wvalid}), 64'd3);
      drain();
      chk("wr_awaddr", 64'(last_awaddr), 64'h10);
      chk("wr_wdata",  last_wdata,       64'h1234);
      chk("wr_wstrb",  64'(last_wstrb),  64'hFF);
      chk("wr_err0",   64'(err_cnt),     64'd0);

      // AWREADY held off 3 cycles, WREADY immediate
      aw_delay = 3; n0 = b_hs_n; r0 = n_rsp;
      send(OP_WRITE, 32'h20, 64'hABCD, 8'h0F, mk(OP_WRITE, 64'h0, AXI_RESP_OKAY));
      drain();
      chk("aw_hi_cycles", 64'(last_aw_hi), 64'd4);
      chk("w_hi_cycles",  64'(last_w_hi),  64'd1);
      chk("b_count",      64'(b_hs_n - n0), 64'd1);
      chk("rsp_count1",   64'(n_rsp - r0), 64'd1);
      aw_delay = 0;

      // backpressure: first command stalls in RSP, four more fill the FIFO
      rsp_ready = 1'b0; r0 = n_rsp;
      rdata_fifo.push_back(64'hC0DE_0001);
      rdata_fifo.push_back(64'hC0DE_0003);
      send(OP_WRITE, 32'h100, 64'h0, 8'h01, mk(OP_WRITE, 64'h0, AXI_RESP_OKAY));
      send(OP_READ,  32'h108, 64'h0, 8'h00, mk(OP_READ, 64'hC0DE_0001, AXI_RESP_OKAY));
      send(OP_WRITE, 32'h110, 64'h2, 8'h03, mk(OP_WRITE, 64'h0, AXI_RESP_OKAY));
      send(OP_READ,  32'h118, 64'h0, 8'h00, mk(OP_READ, 64'hC0DE_0003, AXI_RESP_OKAY));
      send(OP_WRITE, 32'h120, 64'h4, 8'h0F, mk(OP_WRITE, 64'h0, AXI_RESP_OKAY));
      chk("bp_full_ready", 64'(cmd_ready), 64'd0);
      repeat (10) @(negedge clk);
      chk("bp_hold_ready", 64'(cmd_ready), 64'd0);
      chk("bp_rsp_valid",  64'(rsp_valid), 64'd1);
      chk("bp_busy",       64'(busy),      64'd1);
      rsp_ready = 1'b1;
      drain();
      chk("bp_rsp_count", 64'(n_rsp - r0), 64'd5);

      // error reads drive err_cnt to saturation
      rresp_cfg = AXI_RESP_SLVERR; rdata_dflt = 64'hDEAD;
      send(OP_READ, 32'h40, 64'h0, 8'h0, mk(OP_READ, 64'hDEAD, AXI_RESP_SLVERR));
      drain();
      chk("err_cnt_1", 64'(err_cnt), 64'd1);
      for (int i = 0; i < 255; i++)
         send(OP_READ, 32'h40, 64'h0, 8'h0, mk(OP_READ, 64'hDEAD, AXI_RESP_SLVERR));
      drain();
      chk("err_cnt_sat", 64'(err_cnt), 64'hFF);
      send(OP_READ, 32'h40, 64'h0, 8'h0, mk(OP_READ, 64'hDEAD, AXI_RESP_SLVERR));
      drain();
      chk("err_cnt_hold", 64'(err_cnt), 64'hFF);
      rresp_cfg = AXI_RESP_OKAY;

      // reset while ARVALID is waiting for ARREADY
      ar_delay = 6;
      send(OP_READ, 32'h80, 64'h0, 8'h0, mk(OP_READ, 64'h0, AXI_RESP_OKAY));
      n0 = 0;
      while (!arvalid && n0 < 20) begin @(negedge clk); n0++; end
      chk("rst_mid_arvalid_seen", 64'(arvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_arvalid",   64'(arvalid),   64'd0);
      chk("rst_mid_busy",      64'(busy),      64'd0);
      chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      exp_q.delete();
      ar_delay = 0;
      #2 rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst_mid_err_cnt", 64'(err_cnt), 64'd0);
      rdata_dflt = 64'h55AA;
      send(OP_READ, 32'h84, 64'h0, 8'h0, mk(OP_READ, 64'h55AA, AXI_RESP_OKAY));
      drain();
      chk("post_rst_araddr", 64'(last_araddr), 64'h84);

`ifdef AXI_MASTER_POLL_EN
      // poll succeeds on the third read; AR spacing = AR cycle + R cycle + POLL_INTERVAL idle
      rdata_fifo.push_back(64'h1); rdata_fifo.push_back(64'h1); rdata_fifo.push_back(64'h0);
      n0 = ar_hs_n; c0 = ar_cyc.size();
      send(OP_POLL, 32'h200, 64'h1, 8'h0, mk(OP_POLL, 64'h0, AXI_RESP_OKAY));
      drain();
      chk("poll_ar_count", 64'(ar_hs_n - n0), 64'd3);
      if (ar_cyc.size() >= c0 + 3) begin
         chk("poll_gap1", 64'(ar_cyc[c0+1] - ar_cyc[c0]),   64'(POLL_INTERVAL + 2));
         chk("poll_gap2", 64'(ar_cyc[c0+2] - ar_cyc[c0+1]), 64'(POLL_INTERVAL + 2));
      end
      chk("poll_err0", 64'(err_cnt), 64'd0);
      rdata_dflt = 64'h1; n0 = ar_hs_n;
      send(OP_POLL, 32'h200, 64'h1, 8'h0, mk(OP_POLL, 64'h1, AXI_RESP_SLVERR));
      drain();
      chk("poll_to_ar_count", 64'(ar_hs_n - n0), 64'(POLL_MAX));
      chk("poll_to_err", 64'(err_cnt), 64'd1);
`else
      n0 = ar_hs_n;
      send(OP_POLL, 32'h200, 64'h1, 8'h0, mk(OP_POLL, 64'h0, AXI_RESP_SLVERR));
      drain();
      chk("nopoll_ar_count", 64'(ar_hs_n - n0), 64'd0);
      chk("nopoll_err", 64'(err_cnt), 64'd1);
`endif

      // reserved op: error response without any bus traffic
      n0 = ar_hs_n; c0 = aw_hs_n; r0 = w_hs_n;
      send(OP_RSVD, 32'h300, 64'h0, 8'h0, mk(OP_RSVD, 64'h0, AXI_RESP_SLVERR));
      drain();
      chk("rsvd_traffic", 64'((ar_hs_n - n0) + (aw_hs_n - c0) + (w_hs_n - r0)), 64'd0);
      chk("rsvd_err", 64'(err_cnt), 64'd2);
      chk("final_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
